// File: rtl/ex_forward_hazard_unit.sv
// ex_forward_hazard_unit
//   Chooses the EX-stage operand mux selects for each instruction and detects
//   load-use hazards. A small shadow pipeline (EX, MEM, WB) mirrors the
//   destination information of in-flight instructions. The selects are
//   registered on the edge that loads ID/EX, so they arrive in EX together
//   with their instruction.
//
// Ports
//   clock, reset_n        pipeline clock, asynchronous active-low reset
//   id_valid              ID holds a real instruction
//   id_rs, id_rt          source registers of the ID instruction
//   id_uses_rt            ID instruction reads rt as an ALU operand
//   id_dest               destination register of the ID instruction
//   id_reg_write          ID instruction writes the register file
//   id_mem_read           ID instruction is a load
//   flush                 kill the ID instruction this cycle
//   stall                 combinational: hold PC and IF/ID, bubble into ID/EX
//   pc_write_en           ~stall
//   if_id_write_en        ~stall
//   fwd_a_sel, fwd_b_sel  registered EX mux lines: 00 regfile, 01 MEM/WB, 10 EX/MEM
//   stall_count           saturating count of stall cycles
module ex_forward_hazard_unit #(
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   id_valid,
    input  logic [REG_ADDR_W-1:0]  id_rs,
    input  logic [REG_ADDR_W-1:0]  id_rt,
    input  logic                   id_uses_rt,
    input  logic [REG_ADDR_W-1:0]  id_dest,
    input  logic                   id_reg_write,
    input  logic                   id_mem_read,
    input  logic                   flush,
    output logic                   stall,
    output logic                   pc_write_en,
    output logic                   if_id_write_en,
    output logic [1:0]             fwd_a_sel,
    output logic [1:0]             fwd_b_sel,
    output logic [STALL_CNT_W-1:0] stall_count
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dest;
        logic                  reg_write;
        logic                  mem_read;
    } stage_t;

    typedef enum logic [1:0] {
        ST_EX  = 2'd0,
        ST_MEM = 2'd1,
        ST_WB  = 2'd2
    } stage_idx_e;

    localparam logic [1:0] SEL_RF     = 2'b00;
    localparam logic [1:0] SEL_MEM_WB = 2'b01;
    localparam logic [1:0] SEL_EX_MEM = 2'b10;

    stage_t shadow [3];

    logic dispatch;
    logic ex_wr_rs, ex_wr_rt, mem_wr_rs, mem_wr_rt;

    // Register 0 is hard-wired, so a write to it never creates a dependency.
    function automatic logic writes_reg(input stage_t s, input logic [REG_ADDR_W-1:0] r);
        return s.valid & s.reg_write & (s.dest == r) & (r != '0);
    endfunction

    always_comb begin
        ex_wr_rs  = writes_reg(shadow[ST_EX],  id_rs);
        ex_wr_rt  = writes_reg(shadow[ST_EX],  id_rt);
        mem_wr_rs = writes_reg(shadow[ST_MEM], id_rs);
        mem_wr_rt = writes_reg(shadow[ST_MEM], id_rt);

        // A flushed or empty ID slot never stalls.
        stall = id_valid & ~flush & shadow[ST_EX].mem_read &
                (ex_wr_rs | (id_uses_rt & ex_wr_rt));

        dispatch       = id_valid & ~stall & ~flush;
        pc_write_en    = ~stall;
        if_id_write_en = ~stall;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < 3; i++) begin
                shadow[i] <= '0;
            end
            fwd_a_sel   <= SEL_RF;
            fwd_b_sel   <= SEL_RF;
            stall_count <= '0;
        end else begin
            shadow[ST_WB]  <= shadow[ST_MEM];
            shadow[ST_MEM] <= shadow[ST_EX];

            if (dispatch) begin
                shadow[ST_EX] <= '{valid:     1'b1,
                                   dest:      id_dest,
                                   reg_write: id_reg_write,
                                   mem_read:  id_mem_read};
            end else begin
                shadow[ST_EX].valid <= 1'b0;
            end

            // Newest producer wins: EX/MEM beats MEM/WB.
            if (dispatch) begin
                fwd_a_sel <= ex_wr_rs  ? SEL_EX_MEM :
                             mem_wr_rs ? SEL_MEM_WB : SEL_RF;
                fwd_b_sel <= !id_uses_rt ? SEL_RF     :
                             ex_wr_rt    ? SEL_EX_MEM :
                             mem_wr_rt   ? SEL_MEM_WB : SEL_RF;
            end else begin
                fwd_a_sel <= SEL_RF;
                fwd_b_sel <= SEL_RF;
            end

            if (stall && (stall_count != '1)) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end

endmodule

// File: doc/ex_forward_hazard_unit.md
Name: ex_forward_hazard_unit

Overview:
- Decides each instruction's EX-stage operand mux selects and issues them as the 2-bit mux lines.
- The selects are registered on the same clock edge that loads the ID/EX pipeline register, so they reach EX together with their instruction.
- Tracks the destination registers of the instructions in EX, MEM and WB in its own shadow pipeline.
- Detects load-use hazards and stalls the front end while inserting a bubble. Keeps a saturating count of stall cycles.

Parameters:
- REG_ADDR_W, 5, width of a register-file address.
- STALL_CNT_W, 16, width of the stall-cycle counter.

Ports:
- clock, input, 1, pipeline clock; all state updates on posedge.
- reset_n, input, 1, asynchronous active-low reset.
- id_valid, input, 1, the instruction in ID is real (not a bubble).
- id_rs, input, REG_ADDR_W, source A register of the ID instruction.
- id_rt, input, REG_ADDR_W, source B register of the ID instruction.
- id_uses_rt, input, 1, the ID instruction reads rt as an ALU operand.
- id_dest, input, REG_ADDR_W, destination register of the ID instruction.
- id_reg_write, input, 1, the ID instruction writes the register file.
- id_mem_read, input, 1, the ID instruction is a load.
- flush, input, 1, branch taken: kill the ID instruction this cycle.
- stall, output, 1, combinational; hold PC and IF/ID, insert a bubble into ID/EX.
- pc_write_en, output, 1, equals ~stall.
- if_id_write_en, output, 1, equals ~stall.
- fwd_a_sel, output, 2, registered EX mux line for operand A: 00 register file, 01 MEM/WB, 10 EX/MEM.
- fwd_b_sel, output, 2, registered EX mux line for operand B, same encoding.
- stall_count, output, STALL_CNT_W, saturating count of stall cycles.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - ex_/mem_/wb_ shadow valids cleared to 0; all shadow fields cleared to 0.
  - fwd_a_sel=00, fwd_b_sel=00, stall_count=0.
  - stall=0, so pc_write_en=1 and if_id_write_en=1.
  - Reset asserted mid-stall or mid-sequence discards all shadow state immediately.
- Shadow pipeline: each stage holds {valid, dest, reg_write, mem_read}. On every posedge:
  - wb <= mem; mem <= ex.
  - dispatch = id_valid & ~stall & ~flush.
  - ex <= ID fields with valid=1 if dispatch; otherwise ex.valid <= 0 (bubble).
- Hazard qualifier: a stage is "writing r" iff valid & reg_write & dest==r & r!=0. Register 0 never forwards and never stalls.
- stall (combinational from shadow ex and ID inputs):
  - stall = id_valid & ~flush & ex.mem_read & ex "writing id_rs", OR the same with id_rt when id_uses_rt.
  - flush has priority: stall=0 while flush=1.
- Forward selects are computed from the current shadow state and registered at the dispatch edge:
  - fwd_a_sel <= 10 if ex "writing id_rs"; else 01 if mem "writing id_rs"; else 00.
  - fwd_b_sel: same rule against id_rt; forced to 00 if ~id_uses_rt.
  - If not dispatch, both selects <= 00.
  - Newest producer wins: 10 has priority over 01.
- Latency:
  - Selects are valid in the cycle the instruction occupies EX: one clock after the ID cycle.
  - A load-use dependency stalls exactly 1 cycle. The dependent then dispatches with sel=01 (the load is in MEM/WB).
- WB-stage writes are not forwarded. The register file handles write-then-read in the same cycle.
- stall_count increments on every posedge where stall=1 and holds at all-ones (no wrap).
- Simultaneous stall-condition and flush: no stall, bubble inserted, counter unchanged.
- id_valid=0: no stall, bubble inserted, selects 00.

Test Plan:
- Reset: drive reset_n=0 mid-stream with a stall active -> immediately stall=0, fwd sels=00, stall_count=0; after release the first instruction sees no stale forwarding.
- ALU-ALU back-to-back: add r3 (dest=3, rw=1), then sub with rs=3, rt=4 -> the sub's EX cycle shows fwd_a_sel=10, fwd_b_sel=00, stall never asserted.
- Distance-2 dependency: add r5, nop, then or with rt=5 and id_uses_rt=1 -> fwd_b_sel=01. With both EX and MEM writing r5 -> fwd_b_sel=10 (priority).
- Load-use: lw r7 then add with rs=7 -> stall=1 for exactly one cycle, pc_write_en=0, a bubble enters EX, stall_count=1; the add then dispatches with fwd_a_sel=01.
- Register 0 and flush: producer writes r0, consumer reads r0 -> sels 00, no stall. Load-use condition with flush=1 -> stall=0 and a bubble is inserted.
- Saturation: force STALL_CNT_W=4, generate 20 load-use stalls -> stall_count stops at 15.
